// File: rtl/pet_stats_engine_if.sv
// Command handshake bundle between the UART command path and the pet stats engine.
interface pet_stats_engine_if;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       cmd_ready;
  logic       cmd_err;

  modport master (output cmd_valid, output cmd_code, input cmd_ready, input cmd_err);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready, output cmd_err);
endinterface

// File: rtl/pet_stats_engine.sv
// Saturating pet need counters with random tick decay, care commands and an
// awake/asleep state machine keyed off the energy channel.
module pet_stats_engine #(
  parameter int unsigned NUM_STATS  = 5,
  parameter int unsigned STAT_W     = 5,
  parameter int unsigned INIT_VAL   = 16,
  parameter int unsigned CMD_STEP   = 4,
  parameter int unsigned ENERGY_IDX = 3,
  parameter int unsigned ALARM_LVL  = 3,
  parameter int unsigned CRIT_CNT   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick_in,
  input  logic [7:0]                  rnd,
  pet_stats_engine_if.slave           cmd_bus,
  output logic [NUM_STATS*STAT_W-1:0] stats_flat,
  output logic                        is_sleeping,
  output logic [NUM_STATS-1:0]        alarm,
  output logic                        critical,
  output logic [15:0]                 age
);

  localparam int unsigned EXT_W = STAT_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_STATS + 1);
  localparam int unsigned E_IDX = (ENERGY_IDX < NUM_STATS) ? ENERGY_IDX : 0;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_FILL  = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_SLEEP = 3'd4;
  localparam logic [2:0] OP_WAKE  = 3'd5;

  typedef enum logic {AWAKE = 1'b0, ASLEEP = 1'b1} state_t;

  state_t            state_q;
  logic [STAT_W-1:0] stat_q [NUM_STATS];
  logic [STAT_W-1:0] stat_d [NUM_STATS];
  logic [2:0]        op;
  logic [2:0]        idx;
  logic              accept;
  logic              cmd_bad;
  logic              cmd_ok;
  logic [CNT_W-1:0]  zero_cnt;

  assign cmd_bus.cmd_ready = ~reset;
  assign op     = cmd_bus.cmd_code[7:5];
  assign idx    = cmd_bus.cmd_code[2:0];
  assign accept = cmd_bus.cmd_valid & cmd_bus.cmd_ready;
  assign cmd_ok = accept & ~cmd_bad;

  // Rejected commands: reserved opcode, bad channel, or anything but NOP/WAKE while asleep.
  always_comb begin : decode
    cmd_bad = 1'b0;
    if (op[2:1] == 2'b11) cmd_bad = 1'b1;
    if ((op == OP_ADD || op == OP_FILL || op == OP_CLEAR) && 32'(idx) >= NUM_STATS) cmd_bad = 1'b1;
    if (state_q == ASLEEP && op != OP_NOP && op != OP_WAKE) cmd_bad = 1'b1;
    cmd_bad = cmd_bad & accept;
  end

  // Decay first, then the command acts on the decayed value; one clamp at the end.
  always_comb begin : next_stats
    logic [EXT_W-1:0] ext;
    ext = '0;
    for (int k = 0; k < int'(NUM_STATS); k++) begin
      ext = {1'b0, stat_q[k]};
      if (tick_in) begin
        if (state_q == AWAKE) begin
          if (rnd[3'(k)] && stat_q[k] != '0) ext = ext - EXT_W'(1);
        end else if (k == int'(E_IDX) && stat_q[k] != STAT_MAX) begin
          ext = ext + EXT_W'(1);
        end
      end
      if (cmd_ok && idx == 3'(k)) begin
        case (op)
          OP_ADD:   ext = ext + EXT_W'(CMD_STEP);
          OP_FILL:  ext = {1'b0, STAT_MAX};
          OP_CLEAR: ext = '0;
          default:  ;
        endcase
      end
      stat_d[k] = (ext > {1'b0, STAT_MAX}) ? STAT_MAX : ext[STAT_W-1:0];
    end
  end

  always_comb begin : flags
    zero_cnt   = '0;
    alarm      = '0;
    stats_flat = '0;
    for (int k = 0; k < int'(NUM_STATS); k++) begin
      stats_flat[k*STAT_W +: STAT_W] = stat_q[k];
      alarm[k] = (32'(stat_q[k]) <= ALARM_LVL);
      if (stat_q[k] == '0) zero_cnt = zero_cnt + CNT_W'(1);
    end
    critical = (32'(zero_cnt) >= CRIT_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_STATS); k++) stat_q[k] <= STAT_W'(INIT_VAL);
      state_q         <= AWAKE;
      cmd_bus.cmd_err <= 1'b0;
      age             <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STATS); k++) stat_q[k] <= stat_d[k];
      cmd_bus.cmd_err <= cmd_bad;
      if (tick_in && !critical && age != 16'hFFFF) age <= age + 16'd1;
      // Command-driven transitions take priority over the energy-driven ones.
      case (state_q)
        AWAKE: begin
          if (cmd_ok && op == OP_SLEEP)   state_q <= ASLEEP;
          else if (stat_q[E_IDX] == '0)   state_q <= ASLEEP;
        end
        ASLEEP: begin
          if (cmd_ok && op == OP_WAKE)        state_q <= AWAKE;
          else if (stat_q[E_IDX] == STAT_MAX) state_q <= AWAKE;
        end
        default: state_q <= AWAKE;
      endcase
    end
  end

  assign is_sleeping = (state_q == ASLEEP);

endmodule

// File: tb/tb_pet_stats_engine.sv
// Randomised self-checking bench for pet_stats_engine against a plain integer model.
module tb_pet_stats_engine;
  localparam int N    = 5;
  localparam int W    = 5;
  localparam int MAXV = 31;
  localparam int EN   = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick_in = 1'b0;
  logic [7:0]   rnd = 8'h00;
  logic [N*W-1:0] stats_flat;
  logic         is_sleeping;
  logic [N-1:0] alarm;
  logic         critical;
  logic [15:0]  age;

  pet_stats_engine_if bus ();

  pet_stats_engine dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .rnd        (rnd),
    .cmd_bus    (bus),
    .stats_flat (stats_flat),
    .is_sleeping(is_sleeping),
    .alarm      (alarm),
    .critical   (critical),
    .age        (age)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st [N];
  bit m_sleep;
  bit m_err;
  int m_age;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_st[k] = 16;
    m_sleep = 1'b0;
    m_err   = 1'b0;
    m_age   = 0;
  endfunction

  function automatic int zeros();
    int z = 0;
    for (int k = 0; k < N; k++) if (m_st[k] == 0) z++;
    return z;
  endfunction

  function automatic void model_step(input bit tk, input logic [7:0] r, input bit v, input logic [7:0] code);
    int op  = int'(code[7:5]);
    int idx = int'(code[2:0]);
    int nxt [N];
    bit bad, ok, ns;
    bad = (op >= 6) || (op >= 1 && op <= 3 && idx >= N) || (m_sleep && op != 0 && op != 5);
    ok  = v && !bad;
    nxt = m_st;
    if (tk) begin
      if (!m_sleep) begin
        for (int k = 0; k < N; k++) if (r[k] == 1'b1 && nxt[k] > 0) nxt[k] = nxt[k] - 1;
      end else if (nxt[EN] < MAXV) nxt[EN] = nxt[EN] + 1;
    end
    if (ok) begin
      case (op)
        1: nxt[idx] = (nxt[idx] + 4 > MAXV) ? MAXV : nxt[idx] + 4;
        2: nxt[idx] = MAXV;
        3: nxt[idx] = 0;
        default: ;
      endcase
    end
    ns = m_sleep;
    if (ok && !m_sleep && op == 4)      ns = 1'b1;
    else if (ok && m_sleep && op == 5)  ns = 1'b0;
    else if (!m_sleep && m_st[EN] == 0) ns = 1'b1;
    else if (m_sleep && m_st[EN] == MAXV) ns = 1'b0;
    if (tk && zeros() < 2 && m_age < 65535) m_age++;
    m_st    = nxt;
    m_sleep = ns;
    m_err   = v && bad;
  endfunction

  function automatic logic [N*W-1:0] exp_flat();
    logic [N*W-1:0] f = '0;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'(m_st[k]);
    return f;
  endfunction

  function automatic logic [N-1:0] exp_alarm();
    logic [N-1:0] a = '0;
    for (int k = 0; k < N; k++) a[k] = (m_st[k] <= 3);
    return a;
  endfunction

  // One clock of stimulus; the model advances in step with the DUT edge.
  task automatic step(input bit tk, input logic [7:0] r, input bit v, input logic [7:0] code);
    @(negedge clk);
    tick_in = tk; rnd = r; bus.cmd_valid = v; bus.cmd_code = code;
    @(posedge clk);
    model_step(tk, r, v, code);
    #1;
    tick_in = 1'b0; bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
    checks++; if (stats_flat !== {N{5'd16}}) begin errors++; $display("FAIL reset_stats: got %h want %h", stats_flat, {N{5'd16}}); end
    checks++; if (is_sleeping !== 1'b0) begin errors++; $display("FAIL reset_sleep: got %b want 0", is_sleeping); end
    checks++; if (age !== 16'd0) begin errors++; $display("FAIL reset_age: got %0d want 0", age); end
    checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.cmd_err); end
    checks++; if (alarm !== '0 || critical !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0/0", alarm, critical); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_decay();
    repeat (3) step(1'b1, 8'hFF, 1'b0, 8'h00);
    checks++; if (stats_flat !== {N{5'd13}}) begin errors++; $display("FAIL decay_stats: got %h want %h", stats_flat, {N{5'd13}}); end
    checks++; if (age !== 16'd3) begin errors++; $display("FAIL decay_age: got %0d want 3", age); end
    checks++; if (alarm !== '0) begin errors++; $display("FAIL decay_alarm: got %b want 0", alarm); end
  endtask

  task automatic test_add_sat();
    step(1'b0, 8'h00, 1'b1, 8'h42);
    step(1'b1, 8'h04, 1'b0, 8'h00);
    checks++; if (stats_flat[2*W +: W] !== 5'd30) begin errors++; $display("FAIL stat2_30: got %0d want 30", stats_flat[2*W +: W]); end
    step(1'b0, 8'h00, 1'b1, 8'h22);
    checks++; if (stats_flat[2*W +: W] !== 5'd31) begin errors++; $display("FAIL add_saturate: got %0d want 31", stats_flat[2*W +: W]); end
    step(1'b0, 8'h00, 1'b1, 8'h62);
    step(1'b1, 8'h04, 1'b1, 8'h22);
    checks++; if (stats_flat[2*W +: W] !== 5'd4) begin errors++; $display("FAIL tick_plus_add: got %0d want 4", stats_flat[2*W +: W]); end
    checks++; if (stats_flat !== exp_flat()) begin errors++; $display("FAIL add_model: got %h want %h", stats_flat, exp_flat()); end
  endtask

  task automatic test_sleep_cycle();
    logic [W-1:0] s0;
    int n = 0;
    step(1'b0, 8'h00, 1'b1, 8'h63);
    checks++; if (is_sleeping !== 1'b0 || stats_flat[EN*W +: W] !== 5'd0) begin errors++; $display("FAIL clear_energy: got sleep=%b e=%0d want 0/0", is_sleeping, stats_flat[EN*W +: W]); end
    s0 = stats_flat[W-1:0];
    step(1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if (is_sleeping !== 1'b1) begin errors++; $display("FAIL auto_sleep: got %b want 1", is_sleeping); end
    while (m_sleep && n < 40) begin
      step(1'b1, 8'($urandom), 1'b0, 8'h00);
      n++;
      checks++; if (stats_flat !== exp_flat() || is_sleeping !== m_sleep) begin errors++; $display("FAIL sleep_tick: got %h/%b want %h/%b", stats_flat, is_sleeping, exp_flat(), m_sleep); end
    end
    checks++; if (is_sleeping !== 1'b0 || stats_flat[EN*W +: W] !== 5'd31) begin errors++; $display("FAIL auto_wake: got sleep=%b e=%0d want 0/31", is_sleeping, stats_flat[EN*W +: W]); end
    checks++; if (stats_flat[W-1:0] !== s0) begin errors++; $display("FAIL frozen_stat0: got %0d want %0d", stats_flat[W-1:0], s0); end
    checks++; if (n != 32) begin errors++; $display("FAIL wake_ticks: got %0d want 32", n); end
  endtask

  task automatic test_asleep_err();
    logic [W-1:0] s0;
    step(1'b0, 8'h00, 1'b1, 8'h63);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    s0 = stats_flat[W-1:0];
    step(1'b0, 8'h00, 1'b1, 8'h20);
    checks++; if (bus.cmd_err !== 1'b1 || stats_flat[W-1:0] !== s0) begin errors++; $display("FAIL asleep_add: got err=%b s0=%0d want 1/%0d", bus.cmd_err, stats_flat[W-1:0], s0); end
    step(1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", bus.cmd_err); end
    step(1'b0, 8'h00, 1'b1, 8'hA0);
    checks++; if (is_sleeping !== 1'b0) begin errors++; $display("FAIL wake_cmd: got %b want 0", is_sleeping); end
    step(1'b0, 8'h00, 1'b0, 8'h00);
    checks++; if (is_sleeping !== 1'b1) begin errors++; $display("FAIL resleep_zero_energy: got %b want 1", is_sleeping); end
  endtask

  task automatic test_critical();
    logic [15:0] a;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'h60);
    checks++; if (critical !== 1'b0) begin errors++; $display("FAIL one_zero_not_crit: got %b want 0", critical); end
    step(1'b0, 8'h00, 1'b1, 8'h61);
    checks++; if (critical !== 1'b1 || alarm !== 5'b00011) begin errors++; $display("FAIL critical: got %b alarm %b want 1 00011", critical, alarm); end
    a = age;
    repeat (3) step(1'b1, 8'h00, 1'b0, 8'h00);
    checks++; if (age !== a) begin errors++; $display("FAIL age_hold: got %0d want %0d", age, a); end
    step(1'b0, 8'h00, 1'b1, 8'h27);
    checks++; if (bus.cmd_err !== 1'b1) begin errors++; $display("FAIL bad_idx: got %b want 1", bus.cmd_err); end
    step(1'b0, 8'h00, 1'b1, 8'hC1);
    checks++; if (bus.cmd_err !== 1'b1 || stats_flat !== exp_flat()) begin errors++; $display("FAIL reserved_op: got %b %h want 1 %h", bus.cmd_err, stats_flat, exp_flat()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 8'h20);
      checks++; if (stats_flat[W-1:0] !== W'(16 + 4 * i)) begin errors++; $display("FAIL b2b_%0d: got %0d want %0d", i, stats_flat[W-1:0], 16 + 4 * i); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      checks++;
      if (stats_flat !== exp_flat() || is_sleeping !== m_sleep || bus.cmd_err !== m_err ||
          age !== 16'(m_age) || alarm !== exp_alarm() || critical !== (zeros() >= 2)) begin
        errors++;
        $display("FAIL random_%0d: got st=%h sl=%b err=%b age=%0d al=%b cr=%b want st=%h sl=%b err=%b age=%0d al=%b cr=%b",
                 i, stats_flat, is_sleeping, bus.cmd_err, age, alarm, critical,
                 exp_flat(), m_sleep, m_err, m_age, exp_alarm(), (zeros() >= 2));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'h63);
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    @(negedge clk);
    tick_in = 1'b1; rnd = 8'hFF;
    #2 reset = 1'b1;
    #1;
    checks++; if (stats_flat !== {N{5'd16}} || is_sleeping !== 1'b0 || age !== 16'd0) begin errors++; $display("FAIL async_reset: got %h sl=%b age=%0d want %h 0 0", stats_flat, is_sleeping, age, {N{5'd16}}); end
    model_reset();
    @(negedge clk);
    tick_in = 1'b0; reset = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 8'h00;
    test_reset();
    test_decay();
    test_add_sat();
    test_sleep_cycle();
    test_asleep_err();
    test_critical();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
